apb_protocol_monitor: RTL and testbench
=======================================

APB_PROTOCOL_MONITOR -- requirements
Module: apb_protocol_monitor

Interface
REQ-001 Parameter AW, default 32, address width.
REQ-002 Parameter DW, default 32, data width.
REQ-003 Parameter MAX_WAIT, default 16, maximum legal wait states per transfer (>=1).
REQ-004 Parameter CW, default 16, counter width.
REQ-005 PCLK  in  1  sole clock, all state changes on rising edge.
REQ-006 PRESETn  in  1  asynchronous active-low reset.
REQ-007 PADDR in AW, PSEL in 1, PENABLE in 1, PWRITE in 1, PWDATA in DW, PREADY in 1, PRDATA in DW, PSLVERR in 1: observed APB signals, never driven.
REQ-008 i_clear  in  1  synchronous clear of sticky errors, counters and captured address.
REQ-009 o_err  out  8  sticky per-rule violation flags (REQ-016).
REQ-010 o_err_any  out  1  OR of o_err.
REQ-011 o_err_addr  out  AW  PADDR captured at first violation since reset/clear.
REQ-012 o_txn_count  out  CW  completed transfers, wraps modulo 2^CW.
REQ-013 o_slverr_count  out  CW  completed transfers with PSLVERR high, wraps.
REQ-014 o_state  out  2  tracker state: 0 IDLE, 1 SETUP, 2 ACCESS.

Function
REQ-015 Tracker evaluates current-cycle inputs against previous-cycle state each edge; outputs are registered (1-cycle latency from violating cycle to flag).
REQ-016 o_err bits: 0 PENABLE high in IDLE; 1 PENABLE dropped while PSEL high before PREADY; 2 PADDR/PWRITE changed SETUP->end of transfer; 3 PWDATA changed during write transfer; 4 PSLVERR high while PSEL&PENABLE&!PREADY; 5 wait states exceed MAX_WAIT; 6 PSEL dropped before PREADY; 7 APB4 rule (REQ-029).
REQ-017 IDLE: PSEL&!PENABLE -> SETUP, capture PADDR/PWRITE/PWDATA; PENABLE high (any PSEL) -> set bit 0, stay IDLE.
REQ-018 SETUP: PSEL&PENABLE&PREADY -> transfer complete, IDLE; PSEL&PENABLE&!PREADY -> ACCESS, wait counter=1.
REQ-019 SETUP or ACCESS: !PSEL -> set bit 6, IDLE; PSEL&!PENABLE -> set bit 1, IDLE.
REQ-020 ACCESS: PSEL&PENABLE&!PREADY -> stay, wait counter +1 saturating at MAX_WAIT+1; PREADY -> complete, IDLE.
REQ-021 Bit 5 sets on the cycle the wait counter would exceed MAX_WAIT; tracking continues normally.
REQ-022 Stability checks (bits 2, 3) apply each cycle in SETUP/ACCESS with PSEL high, compared to captured values; bit 3 only when captured PWRITE=1.
REQ-023 Completion: o_txn_count +1; o_slverr_count +1 if PSLVERR high on the completing cycle.
REQ-024 Back-to-back: completing-cycle state IDLE, next cycle PSEL&!PENABLE starts a new SETUP with no error.
REQ-025 Multiple violations in one cycle set all corresponding bits; o_err_addr captures current PADDR only if o_err was all zero before.
REQ-026 i_clear simultaneous with a violation: clear wins, violation lost; state tracking unaffected by i_clear.

Reset
REQ-027 PRESETn low: o_state=IDLE, o_err=0, o_err_any=0, o_err_addr=0, both counts=0, wait counter=0, captured values=0, immediately and independent of PCLK.
REQ-028 Reset mid-transfer abandons it without count or error; first post-reset cycle treated from IDLE.

Configuration
REQ-029 Macro APB4_MONITOR_EN defined: adds inputs PSTRB (DW/8) and PPROT (3), captured at SETUP; bit 7 sets if either changes during the transfer or PSTRB nonzero on a read.
REQ-030 Macro undefined: PSTRB/PPROT ports absent, o_err[7] tied 0.

Verification
REQ-031 Reset, then write PADDR=0x10, PWDATA=0xA5, zero wait -> o_txn_count=1, o_err=0x00.
REQ-032 Read, PREADY low 3 cycles, PSLVERR high on completion -> o_txn_count=1, o_slverr_count=1, o_err=0x00.
REQ-033 PENABLE high with PSEL low from IDLE at PADDR=0x44 -> o_err=0x01, o_err_addr=0x44, o_err_any=1.
REQ-034 MAX_WAIT=16, PREADY held low 17 ACCESS-phase cycles -> bit 5 set one cycle after 17th; completion still counted.
REQ-035 Write with PWDATA changed in ACCESS, PSEL dropped before PREADY -> o_err=0x48, count unchanged, o_state=IDLE; then i_clear -> o_err=0x00, counts 0.
REQ-036 APB4_MONITOR_EN: read with PSTRB=0xF -> o_err=0x80; macro undefined, same stimulus minus PSTRB -> o_err=0x00.

Source files
------------

// File: rtl/apb_protocol_monitor.sv
// Passive APB protocol checker: sticky rule flags, first-fault address, transfer counters.
// Define APB4_MONITOR_EN to add PSTRB/PPROT observation and rule bit 7.
module apb_protocol_monitor #(
    parameter int AW       = 32,
    parameter int DW       = 32,
    parameter int MAX_WAIT = 16,
    parameter int CW       = 16
) (
    input  logic          PCLK,
    input  logic          PRESETn,
    input  logic [AW-1:0] PADDR,
    input  logic          PSEL,
    input  logic          PENABLE,
    input  logic          PWRITE,
    input  logic [DW-1:0] PWDATA,
    input  logic          PREADY,
    input  logic [DW-1:0] PRDATA,
    input  logic          PSLVERR,
`ifdef APB4_MONITOR_EN
    input  logic [DW/8-1:0] PSTRB,
    input  logic [2:0]    PPROT,
`endif
    input  logic          i_clear,
    output logic [7:0]    o_err,
    output logic          o_err_any,
    output logic [AW-1:0] o_err_addr,
    output logic [CW-1:0] o_txn_count,
    output logic [CW-1:0] o_slverr_count,
    output logic [1:0]    o_state
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETUP  = 2'd1,
        S_ACCESS = 2'd2
    } state_e;

    localparam int WW = $clog2(MAX_WAIT + 2);
    localparam logic [WW-1:0] W_LIM = WW'(MAX_WAIT);
    localparam logic [WW-1:0] W_SAT = WW'(MAX_WAIT + 1);

    state_e        state_q, state_d;
    logic [WW-1:0] wait_q, wait_d;
    logic [7:0]    err_q;
    logic [AW-1:0] eaddr_q;
    logic [CW-1:0] txn_q;
    logic [CW-1:0] slv_q;
    logic [AW-1:0] addr_q;
    logic          pwrite_q;
    logic [DW-1:0] wdata_q;
`ifdef APB4_MONITOR_EN
    logic [DW/8-1:0] strb_q;
    logic [2:0]    prot_q;
`endif

    logic [7:0] viol;
    logic       done;
    logic       cap;
    logic       unused_prdata;

    assign unused_prdata = ^PRDATA;

    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        viol    = '0;
        done    = 1'b0;
        cap     = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (PENABLE) begin
                    viol[0] = 1'b1;
                end else if (PSEL) begin
                    state_d = S_SETUP;
                    cap     = 1'b1;
                end
            end
            S_SETUP, S_ACCESS: begin
                if (!PSEL) begin
                    viol[6] = 1'b1;
                    state_d = S_IDLE;
                end else if (!PENABLE) begin
                    viol[1] = 1'b1;
                    state_d = S_IDLE;
                end else if (PREADY) begin
                    done    = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    state_d = S_ACCESS;
                    if (state_q == S_SETUP) begin
                        wait_d = WW'(1);
                    end else if (wait_q != W_SAT) begin
                        wait_d = wait_q + WW'(1);
                        if (wait_q == W_LIM) viol[5] = 1'b1;
                    end
                end
                // Stability is judged against the values seen at SETUP
                if (PSEL) begin
                    if (PADDR != addr_q || PWRITE != pwrite_q) viol[2] = 1'b1;
                    if (pwrite_q && PWDATA != wdata_q) viol[3] = 1'b1;
                    if (PENABLE && !PREADY && PSLVERR) viol[4] = 1'b1;
`ifdef APB4_MONITOR_EN
                    if (PSTRB != strb_q || PPROT != prot_q ||
                        (!pwrite_q && PSTRB != '0)) viol[7] = 1'b1;
`endif
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q  <= S_IDLE;
            wait_q   <= '0;
            err_q    <= '0;
            eaddr_q  <= '0;
            txn_q    <= '0;
            slv_q    <= '0;
            addr_q   <= '0;
            pwrite_q <= 1'b0;
            wdata_q  <= '0;
`ifdef APB4_MONITOR_EN
            strb_q   <= '0;
            prot_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            if (cap) begin
                addr_q   <= PADDR;
                pwrite_q <= PWRITE;
                wdata_q  <= PWDATA;
`ifdef APB4_MONITOR_EN
                strb_q   <= PSTRB;
                prot_q   <= PPROT;
`endif
            end
            if (i_clear) begin
                err_q   <= '0;
                eaddr_q <= '0;
                txn_q   <= '0;
                slv_q   <= '0;
            end else begin
                if (done) txn_q <= txn_q + CW'(1);
                if (done && PSLVERR) slv_q <= slv_q + CW'(1);
                if (|viol) begin
                    err_q <= err_q | viol;
                    if (err_q == '0) eaddr_q <= PADDR;
                end
            end
        end
    end

    assign o_err          = err_q;
    assign o_err_any      = |err_q;
    assign o_err_addr     = eaddr_q;
    assign o_txn_count    = txn_q;
    assign o_slverr_count = slv_q;
    assign o_state        = state_q;

endmodule

// File: tb/tb_apb_protocol_monitor.sv
// Directed table-driven bench for apb_protocol_monitor.
// Honors APB4_MONITOR_EN for the PSTRB read rule.
module tb_apb_protocol_monitor;

    logic        PCLK = 1'b0;
    logic        PRESETn = 1'b0;
    logic [31:0] PADDR = '0;
    logic        PSEL = 1'b0;
    logic        PENABLE = 1'b0;
    logic        PWRITE = 1'b0;
    logic [31:0] PWDATA = '0;
    logic        PREADY = 1'b0;
    logic [31:0] PRDATA = '0;
    logic        PSLVERR = 1'b0;
`ifdef APB4_MONITOR_EN
    logic [3:0]  PSTRB = '0;
    logic [2:0]  PPROT = '0;
    localparam logic [7:0]  E7 = 8'h80;
    localparam logic [31:0] A7 = 32'h90;
`else
    localparam logic [7:0]  E7 = 8'h00;
    localparam logic [31:0] A7 = 32'h0;
`endif
    logic        i_clear = 1'b0;
    logic [7:0]  o_err;
    logic        o_err_any;
    logic [31:0] o_err_addr;
    logic [15:0] o_txn_count;
    logic [15:0] o_slverr_count;
    logic [1:0]  o_state;

    int checks = 0;
    int errors = 0;

    apb_protocol_monitor #(
        .AW(32), .DW(32), .MAX_WAIT(16), .CW(16)
    ) dut (
        .PCLK(PCLK), .PRESETn(PRESETn), .PADDR(PADDR),
        .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
        .PWDATA(PWDATA), .PREADY(PREADY), .PRDATA(PRDATA),
        .PSLVERR(PSLVERR),
`ifdef APB4_MONITOR_EN
        .PSTRB(PSTRB), .PPROT(PPROT),
`endif
        .i_clear(i_clear), .o_err(o_err), .o_err_any(o_err_any),
        .o_err_addr(o_err_addr), .o_txn_count(o_txn_count),
        .o_slverr_count(o_slverr_count), .o_state(o_state)
    );

    always #5 PCLK = ~PCLK;

    typedef struct {
        logic        sel, en, wr, rdy, slv, clr;
        logic [31:0] addr, wd;
        logic [3:0]  strb;
        logic [7:0]  e_err;
        logic [1:0]  e_st;
        logic [15:0] e_txn, e_slv;
        logic [31:0] e_addr;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(
        logic sel, logic en, logic wr, logic rdy, logic slv, logic clr,
        logic [31:0] addr, logic [31:0] wd, logic [3:0] strb,
        logic [7:0] e_err, logic [1:0] e_st,
        logic [15:0] e_txn, logic [15:0] e_slv, logic [31:0] e_addr);
        vec_t v;
        v.sel = sel; v.en = en; v.wr = wr; v.rdy = rdy;
        v.slv = slv; v.clr = clr; v.addr = addr; v.wd = wd;
        v.strb = strb; v.e_err = e_err; v.e_st = e_st;
        v.e_txn = e_txn; v.e_slv = e_slv; v.e_addr = e_addr;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", nm, got, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        @(negedge PCLK);
        PSEL = v.sel; PENABLE = v.en; PWRITE = v.wr;
        PREADY = v.rdy; PSLVERR = v.slv; i_clear = v.clr;
        PADDR = v.addr; PWDATA = v.wd;
`ifdef APB4_MONITOR_EN
        PSTRB = v.strb;
`endif
        @(posedge PCLK);
        #1;
    endtask

    task automatic chk_all(input string nm, input vec_t v);
        chk({nm, ".err"}, 32'(o_err), 32'(v.e_err));
        chk({nm, ".any"}, 32'(o_err_any), 32'(|v.e_err));
        chk({nm, ".state"}, 32'(o_state), 32'(v.e_st));
        chk({nm, ".txn"}, 32'(o_txn_count), 32'(v.e_txn));
        chk({nm, ".slv"}, 32'(o_slverr_count), 32'(v.e_slv));
        chk({nm, ".eaddr"}, o_err_addr, v.e_addr);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: got running want finished");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t idle;
        vec_t acc;
        idle = mk(0,0,0,0,0,0, 32'h0, 32'h0, 4'h0, 8'h00,0,0,0,32'h0);
        // write 0x10 zero wait, then clear
        tbl.push_back(mk(1,0,1,0,0,0, 32'h10,32'hA5,0, 8'h00,1,0,0,32'h0));
        tbl.push_back(mk(1,1,1,1,0,0, 32'h10,32'hA5,0, 8'h00,0,1,0,32'h0));
        tbl.push_back(mk(0,0,0,0,0,1, 32'h0,32'h0,0, 8'h00,0,0,0,32'h0));
        // read, 3 waits, slave error on completion
        tbl.push_back(mk(1,0,0,0,0,0, 32'h20,32'h0,0, 8'h00,1,0,0,32'h0));
        tbl.push_back(mk(1,1,0,0,0,0, 32'h20,32'h0,0, 8'h00,2,0,0,32'h0));
        tbl.push_back(mk(1,1,0,0,0,0, 32'h20,32'h0,0, 8'h00,2,0,0,32'h0));
        tbl.push_back(mk(1,1,0,0,0,0, 32'h20,32'h0,0, 8'h00,2,0,0,32'h0));
        tbl.push_back(mk(1,1,0,1,1,0, 32'h20,32'h0,0, 8'h00,0,1,1,32'h0));
        // back-to-back write
        tbl.push_back(mk(1,0,1,0,0,0, 32'h30,32'h11,0, 8'h00,1,1,1,32'h0));
        tbl.push_back(mk(1,1,1,1,0,0, 32'h30,32'h11,0, 8'h00,0,2,1,32'h0));
        tbl.push_back(mk(0,0,0,0,0,1, 32'h0,32'h0,0, 8'h00,0,0,0,32'h0));
        // PENABLE in IDLE
        tbl.push_back(mk(0,1,0,0,0,0, 32'h44,32'h0,0, 8'h01,0,0,0,32'h44));
        tbl.push_back(idle);
        tbl[$].e_err = 8'h01;
        tbl[$].e_addr = 32'h44;
        tbl.push_back(mk(0,0,0,0,0,1, 32'h0,32'h0,0, 8'h00,0,0,0,32'h0));
        // PWDATA change then PSEL drop
        tbl.push_back(mk(1,0,1,0,0,0, 32'h50,32'h1,0, 8'h00,1,0,0,32'h0));
        tbl.push_back(mk(1,1,1,0,0,0, 32'h50,32'h1,0, 8'h00,2,0,0,32'h0));
        tbl.push_back(mk(1,1,1,0,0,0, 32'h50,32'h2,0, 8'h08,2,0,0,32'h50));
        tbl.push_back(mk(0,0,1,0,0,0, 32'h50,32'h2,0, 8'h48,0,0,0,32'h50));
        tbl.push_back(mk(0,0,0,0,0,1, 32'h0,32'h0,0, 8'h00,0,0,0,32'h0));
        // clear beats a simultaneous violation
        tbl.push_back(mk(0,1,0,0,0,1, 32'h60,32'h0,0, 8'h00,0,0,0,32'h0));
        // address change plus early PSLVERR in one cycle
        tbl.push_back(mk(1,0,0,0,0,0, 32'h70,32'h0,0, 8'h00,1,0,0,32'h0));
        tbl.push_back(mk(1,1,0,0,1,0, 32'h74,32'h0,0, 8'h14,2,0,0,32'h74));
        tbl.push_back(mk(1,1,0,1,0,0, 32'h70,32'h0,0, 8'h14,0,1,0,32'h74));
        tbl.push_back(mk(0,0,0,0,0,1, 32'h0,32'h0,0, 8'h00,0,0,0,32'h0));
        // PENABLE never raised after SETUP
        tbl.push_back(mk(1,0,1,0,0,0, 32'h80,32'h0,0, 8'h00,1,0,0,32'h0));
        tbl.push_back(mk(1,0,1,0,0,0, 32'h80,32'h0,0, 8'h02,0,0,0,32'h80));
        tbl.push_back(mk(0,0,0,0,0,1, 32'h0,32'h0,0, 8'h00,0,0,0,32'h0));
        // read with strobes set
        tbl.push_back(mk(1,0,0,0,0,0, 32'h90,32'h0,4'hF, 8'h00,1,0,0,32'h0));
        tbl.push_back(mk(1,1,0,1,0,0, 32'h90,32'h0,4'hF, E7,0,1,0,A7));
        tbl.push_back(mk(0,0,0,0,0,1, 32'h0,32'h0,0, 8'h00,0,0,0,32'h0));

        #12;
        chk_all("reset", idle);
        @(negedge PCLK);
        PRESETn = 1'b1;

        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i]);
            chk_all($sformatf("v%0d", i), tbl[i]);
        end

        // 17 PREADY-low cycles against MAX_WAIT=16
        drive(mk(1,0,0,0,0,0, 32'hA0,32'h0,0, 0,0,0,0,0));
        acc = mk(1,1,0,0,0,0, 32'hA0,32'h0,0, 0,0,0,0,0);
        for (int i = 1; i <= 17; i++) begin
            drive(acc);
            if (i == 16) begin
                chk("wait16.err", 32'(o_err), 32'h0);
                chk("wait16.state", 32'(o_state), 32'd2);
            end
        end
        chk("wait17.err", 32'(o_err), 32'h20);
        chk("wait17.eaddr", o_err_addr, 32'hA0);
        drive(mk(1,1,0,1,0,0, 32'hA0,32'h0,0, 0,0,0,0,0));
        chk("waitdone.txn", 32'(o_txn_count), 32'd1);
        chk("waitdone.err", 32'(o_err), 32'h20);
        chk("waitdone.state", 32'(o_state), 32'd0);

        // async reset in the middle of a transfer
        drive(mk(1,0,0,0,0,0, 32'hB0,32'h0,0, 0,0,0,0,0));
        drive(mk(1,1,0,0,0,0, 32'hB0,32'h0,0, 0,0,0,0,0));
        chk("mid.state", 32'(o_state), 32'd2);
        #2;
        PRESETn = 1'b0;
        #1;
        chk("arst.state", 32'(o_state), 32'd0);
        chk("arst.txn", 32'(o_txn_count), 32'd0);
        chk("arst.err", 32'(o_err), 32'h0);
        chk("arst.any", 32'(o_err_any), 32'h0);
        @(negedge PCLK);
        PRESETn = 1'b1;
        PREADY = 1'b1;
        @(posedge PCLK);
        #1;
        chk("post.err", 32'(o_err), 32'h01);
        chk("post.txn", 32'(o_txn_count), 32'd0);
        chk("post.state", 32'(o_state), 32'd0);
        chk("post.eaddr", o_err_addr, 32'hB0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
